// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the baud divider helper.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } uart_rx_state_t;

  localparam int UART_DATA_BITS = 8;

  // Clocks per oversample tick; integer divide, so the baud error is the caller's concern.
  function automatic int uart_div(input int clk_freq, input int baud_rate, input int os);
    return clk_freq / (baud_rate * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running 0..DIV-1 counter, tick on DIV-1, synchronous clear.
// Written to be shared with the transmitter.
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver (8N1, LSB first) with a valid/ack byte handshake.
// Define UART_RX_PARITY_EN to expect an even-parity bit and expose parity_err.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int clk_freq   = 1000000,
  parameter int baud_rate  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  input  logic                      rx_ack,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                      parity_err
`endif
);

  localparam int DIV = uart_div(clk_freq, baud_rate, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(UART_DATA_BITS);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(UART_DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam uart_rx_state_t AFTER_DATA = RX_PARITY;
`else
  localparam uart_rx_state_t AFTER_DATA = RX_STOP;
`endif

  if (DIV < 2) begin : g_div_chk
    $error("uart_rx_os: clock divider DIV=%0d is below 2", DIV);
  end
  if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0)) begin : g_os_chk
    $error("uart_rx_os: OVERSAMPLE=%0d must be even and >= 8", OVERSAMPLE);
  end

  uart_rx_state_t state, state_nx;

  logic                      rx_meta, rx_s, rx_prev;
  logic                      tick, fall, mid, bit_end;
  logic                      start_det, start_ok, data_smp, stop_smp;
  logic [SW-1:0]             s;
  logic [BW-1:0]             bit_cnt;
  logic [UART_DATA_BITS-1:0] shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall    = rx_prev & ~rx_s;
  assign mid     = tick && (s == S_MID);
  assign bit_end = tick && (s == S_LAST);
  assign busy    = (state != RX_IDLE);

  // Clearing the divider on the edge phase-locks all later ticks to the start bit.
  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_det),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start_det = 1'b0;
    start_ok  = 1'b0;
    data_smp  = 1'b0;
    stop_smp  = 1'b0;
    case (state)
      RX_IDLE: begin
        if (fall) begin
          start_det = 1'b1;
          state_nx  = RX_START;
        end
      end
      RX_START: begin
        if (mid) begin
          if (!rx_s) begin
            start_ok = 1'b1;
            state_nx = RX_DATA;
          end else begin
            state_nx = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (bit_end) begin
          data_smp = 1'b1;
          if (bit_cnt == B_LAST) state_nx = AFTER_DATA;
        end
      end
      RX_PARITY: begin
        if (bit_end) state_nx = RX_STOP;
      end
      RX_STOP: begin
        if (bit_end) begin
          stop_smp = 1'b1;
          state_nx = RX_IDLE;
        end
      end
      default: state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s         <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // After the start-bit mid, each wrap of s lands on the middle of the next bit.
      if (start_det || start_ok) s <= '0;
      else if (tick)             s <= (s == S_LAST) ? '0 : s + SW'(1);

      if (start_ok)      bit_cnt <= '0;
      else if (data_smp) bit_cnt <= bit_cnt + BW'(1);

      if (data_smp) shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};

      if (rx_ack && rx_valid) rx_valid <= 1'b0;

      // An ack in the same clock frees the holding register, so the new byte loads.
      if (stop_smp) begin
        if (!rx_s) begin
          frame_err <= 1'b1;
        end else if (!rx_valid || rx_ack) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      if ((state == RX_PARITY) && bit_end) par_bit <= rx_s;
      if (stop_smp) parity_err <= ^{shreg, par_bit};
    end
  end
`endif

endmodule
